// File: rtl/game_flow_ctrl.sv
// Play-session sequencer: synchronizes frame strobe and keys, runs the
// idle/countdown/play/pause/result FSM and gates the song timer inputs.
module game_flow_ctrl #(
   parameter int FPS            = 60,
   parameter int COUNTDOWN_SECS = 3,
   parameter int RESULT_SECS    = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       new_frame,
   input  logic       start_key,
   input  logic       pause_key,
   input  logic       abort_key,
   input  logic       timer_stop,
   output logic       timer_frame,
   output logic       timer_start,
   output logic       timer_clear,
   output logic       frame_en,
   output logic [2:0] game_state,
   output logic [3:0] countdown
);

   localparam int FW = (FPS > 1) ? $clog2(FPS) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CD     = 3'd1,
      S_PLAY   = 3'd2,
      S_PAUSE  = 3'd3,
      S_RESULT = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [3:0]    scnt_q, scnt_d;
   logic          tstart_q, tstart_d;
   logic [3:0]    sync1_q, sync2_q, hist_q;
   logic [3:0]    ev;
   logic          tick, start_ev, pause_ev, abort_ev;
   logic          wrap, last_sec;

   // History resets to 0, so a key held through reset yields one late event.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         hist_q  <= '0;
      end else begin
         sync1_q <= {abort_key, pause_key, start_key, new_frame};
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end

   assign ev       = sync2_q & ~hist_q;
   assign tick     = ev[0];
   assign start_ev = ev[1];
   assign pause_ev = ev[2];
   assign abort_ev = ev[3];

   assign wrap     = tick && (fcnt_q == FW'(FPS - 1));
   assign last_sec = wrap && (scnt_q == 4'd1);

   always_comb begin
      state_d  = state_q;
      fcnt_d   = fcnt_q;
      scnt_d   = scnt_q;
      tstart_d = 1'b0;
      // Shared seconds/frames countdown, only consumed in COUNTDOWN and RESULT.
      if (tick && (state_q == S_CD || state_q == S_RESULT)) begin
         if (wrap) begin
            fcnt_d = '0;
            scnt_d = scnt_q - 4'd1;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
      case (state_q)
         S_IDLE: begin
            if (start_ev) begin
               state_d = S_CD;
               scnt_d  = 4'(COUNTDOWN_SECS);
               fcnt_d  = '0;
            end
         end
         S_CD: begin
            if (abort_ev) begin
               state_d = S_IDLE;
            end else if (last_sec) begin
               state_d  = S_PLAY;
               tstart_d = 1'b1;
            end
         end
         S_PLAY: begin
            if (abort_ev) begin
               state_d = S_IDLE;
            end else if (timer_stop) begin
               state_d = S_RESULT;
               scnt_d  = 4'(RESULT_SECS);
               fcnt_d  = '0;
            end else if (pause_ev) begin
               state_d = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (abort_ev)      state_d = S_IDLE;
            else if (pause_ev) state_d = S_PLAY;
         end
         S_RESULT: begin
            if (abort_ev || start_ev || last_sec) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         fcnt_q   <= '0;
         scnt_q   <= '0;
         tstart_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         fcnt_q   <= fcnt_d;
         scnt_q   <= scnt_d;
         tstart_q <= tstart_d;
      end
   end

   assign timer_frame = tick && (state_q == S_PLAY);
   assign frame_en    = timer_frame;
   assign timer_start = tstart_q;
   assign timer_clear = (state_q == S_IDLE);
   assign game_state  = state_q;
   assign countdown   = (state_q == S_CD) ? scnt_q : 4'd0;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Vector table plus scoreboard bench for game_flow_ctrl at default parameters.
module tb_game_flow_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       new_frame = 1'b0, start_key = 1'b0, pause_key = 1'b0, abort_key = 1'b0;
   logic       timer_stop = 1'b0;
   logic       timer_frame, timer_start, timer_clear, frame_en;
   logic [2:0] game_state;
   logic [3:0] countdown;

   game_flow_ctrl dut (
      .clk(clk), .reset(reset), .new_frame(new_frame), .start_key(start_key),
      .pause_key(pause_key), .abort_key(abort_key), .timer_stop(timer_stop),
      .timer_frame(timer_frame), .timer_start(timer_start), .timer_clear(timer_clear),
      .frame_en(frame_en), .game_state(game_state), .countdown(countdown)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0;
   int fe_cnt = 0, ts_cnt = 0, ts_wide = 0, fe_tf_bad = 0, cd_entries = 0;
   logic       prev_ts = 1'b0;
   logic [2:0] prev_gs = 3'd0;

   always @(negedge clk) begin
      if (frame_en) fe_cnt <= fe_cnt + 1;
      if (timer_start) ts_cnt <= ts_cnt + 1;
      if (timer_start && prev_ts) ts_wide <= ts_wide + 1;
      if (frame_en !== timer_frame) fe_tf_bad <= fe_tf_bad + 1;
      if (game_state == 3'd1 && prev_gs != 3'd1) cd_entries <= cd_entries + 1;
      prev_ts <= timer_start;
      prev_gs <= game_state;
   end

   typedef enum {OP_START, OP_PAUSE, OP_ABORT, OP_FRAMES, OP_STOP} op_t;
   typedef struct {
      op_t        op;
      int         n;
      logic [2:0] gs;
      logic [3:0] cd;
      logic       clr;
      int         fe;
      int         ts;
   } vec_t;
   typedef struct {
      string      name;
      logic [2:0] gs;
      logic [3:0] cd;
      logic       clr;
      int         fe;
      int         ts;
      int         fe_base;
      int         ts_base;
   } exp_t;

   vec_t vecs[$];
   exp_t sbq[$];

   function automatic vec_t mk(op_t op, int n, int gs, int cd, int clr, int fe, int ts);
      vec_t v;
      v.op = op; v.n = n; v.gs = 3'(gs); v.cd = 4'(cd); v.clr = 1'(clr);
      v.fe = fe; v.ts = ts;
      return v;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sb_push(string name, int gs, int cd, int clr, int fe, int ts);
      exp_t e;
      e.name = name; e.gs = 3'(gs); e.cd = 4'(cd); e.clr = 1'(clr);
      e.fe = fe; e.ts = ts; e.fe_base = fe_cnt; e.ts_base = ts_cnt;
      sbq.push_back(e);
   endtask

   task automatic sb_check();
      exp_t e;
      if (sbq.size() == 0) begin
         chk("scoreboard_empty", 0, 1);
         return;
      end
      e = sbq.pop_front();
      chk({e.name, " game_state"}, int'(game_state), int'(e.gs));
      chk({e.name, " countdown"}, int'(countdown), int'(e.cd));
      chk({e.name, " timer_clear"}, int'(timer_clear), int'(e.clr));
      chk({e.name, " frame_en pulses"}, fe_cnt - e.fe_base, e.fe);
      chk({e.name, " timer_start pulses"}, ts_cnt - e.ts_base, e.ts);
   endtask

   task automatic frames(int n);
      for (int i = 0; i < n; i++) begin
         new_frame = 1'b1; step(3);
         new_frame = 1'b0; step(3);
      end
   endtask

   task automatic do_op(op_t op, int n);
      case (op)
         OP_START:  begin start_key = 1'b1; step(4); start_key = 1'b0; step(4); end
         OP_PAUSE:  begin pause_key = 1'b1; step(4); pause_key = 1'b0; step(4); end
         OP_ABORT:  begin abort_key = 1'b1; step(4); abort_key = 1'b0; step(4); end
         OP_FRAMES: frames(n);
         OP_STOP:   begin timer_stop = 1'b1; step(1); timer_stop = 1'b0; step(2); end
         default:   step(1);
      endcase
   endtask

   initial begin
      int base;
      // Session walk: start, countdown digits, play, pause, song end, aborts.
      vecs.push_back(mk(OP_START,    0, 1, 3, 0,  0, 0));
      vecs.push_back(mk(OP_FRAMES,  59, 1, 3, 0,  0, 0));
      vecs.push_back(mk(OP_FRAMES,   1, 1, 2, 0,  0, 0));
      vecs.push_back(mk(OP_PAUSE,    0, 1, 2, 0,  0, 0));
      vecs.push_back(mk(OP_FRAMES,  60, 1, 1, 0,  0, 0));
      vecs.push_back(mk(OP_FRAMES,  59, 1, 1, 0,  0, 0));
      vecs.push_back(mk(OP_FRAMES,   1, 2, 0, 0,  0, 1));
      vecs.push_back(mk(OP_FRAMES,  10, 2, 0, 0, 10, 0));
      vecs.push_back(mk(OP_START,    0, 2, 0, 0,  0, 0));
      vecs.push_back(mk(OP_PAUSE,    0, 3, 0, 0,  0, 0));
      vecs.push_back(mk(OP_FRAMES,   5, 3, 0, 0,  0, 0));
      vecs.push_back(mk(OP_START,    0, 3, 0, 0,  0, 0));
      vecs.push_back(mk(OP_PAUSE,    0, 2, 0, 0,  0, 0));
      vecs.push_back(mk(OP_FRAMES,   3, 2, 0, 0,  3, 0));
      vecs.push_back(mk(OP_STOP,     0, 4, 0, 0,  0, 0));
      vecs.push_back(mk(OP_FRAMES, 299, 4, 0, 0,  0, 0));
      vecs.push_back(mk(OP_FRAMES,   1, 0, 0, 1,  0, 0));
      vecs.push_back(mk(OP_PAUSE,    0, 0, 0, 1,  0, 0));
      vecs.push_back(mk(OP_ABORT,    0, 0, 0, 1,  0, 0));
      vecs.push_back(mk(OP_START,    0, 1, 3, 0,  0, 0));
      vecs.push_back(mk(OP_FRAMES,  60, 1, 2, 0,  0, 0));
      vecs.push_back(mk(OP_ABORT,    0, 0, 0, 1,  0, 0));
      vecs.push_back(mk(OP_START,    0, 1, 3, 0,  0, 0));
      vecs.push_back(mk(OP_FRAMES, 180, 2, 0, 0,  0, 1));
      vecs.push_back(mk(OP_STOP,     0, 4, 0, 0,  0, 0));
      vecs.push_back(mk(OP_FRAMES,  61, 4, 0, 0,  0, 0));
      vecs.push_back(mk(OP_START,    0, 0, 0, 1,  0, 0));
      vecs.push_back(mk(OP_START,    0, 1, 3, 0,  0, 0));
      vecs.push_back(mk(OP_FRAMES, 180, 2, 0, 0,  0, 1));

      #13;
      chk("reset game_state", int'(game_state), 0);
      chk("reset countdown", int'(countdown), 0);
      chk("reset timer_clear", int'(timer_clear), 1);
      chk("reset timer_start", int'(timer_start), 0);
      chk("reset frame_en", int'(frame_en), 0);
      #10 reset = 1'b1;
      step(3);

      foreach (vecs[i]) begin
         sb_push($sformatf("v%0d", i), vecs[i].gs, vecs[i].cd, vecs[i].clr,
                 vecs[i].fe, vecs[i].ts);
         do_op(vecs[i].op, vecs[i].n);
         sb_check();
      end

      // Abort beats pause and timer_stop when all land on the same edge.
      abort_key = 1'b1; pause_key = 1'b1;
      step(2);
      timer_stop = 1'b1;
      sb_push("abort_pause_stop", 0, 0, 1, 0, 0);
      step(1);
      timer_stop = 1'b0;
      sb_check();
      abort_key = 1'b0; pause_key = 1'b0;
      step(4);

      do_op(OP_START, 0);
      frames(180);
      // timer_stop beats pause in PLAY.
      pause_key = 1'b1;
      step(2);
      timer_stop = 1'b1;
      sb_push("pause_stop", 4, 0, 0, 0, 0);
      step(1);
      timer_stop = 1'b0;
      sb_check();
      pause_key = 1'b0;
      step(4);
      do_op(OP_ABORT, 0);

      // Exact two-edge latency, and a long hold yields a single entry.
      base = cd_entries;
      start_key = 1'b1;
      step(2);
      chk("start latency edge k+1", int'(game_state), 0);
      step(1);
      chk("start latency edge k+2", int'(game_state), 1);
      step(997);
      start_key = 1'b0;
      step(4);
      chk("held start entries", cd_entries - base, 1);
      chk("held start countdown", int'(countdown), 3);

      frames(180);
      chk("replay state", int'(game_state), 2);
      new_frame = 1'b1;
      step(2);
      chk("tick forwarded to frame_en", int'(frame_en), 1);
      #2 reset = 1'b0;
      #1;
      chk("async reset game_state", int'(game_state), 0);
      chk("async reset countdown", int'(countdown), 0);
      chk("async reset timer_clear", int'(timer_clear), 1);
      chk("async reset frame_en", int'(frame_en), 0);
      chk("async reset timer_frame", int'(timer_frame), 0);
      chk("async reset timer_start", int'(timer_start), 0);
      new_frame = 1'b0;
      step(2);
      reset = 1'b1;
      step(3);

      chk("timer_start width", ts_wide, 0);
      chk("frame_en equals timer_frame", fe_tf_bad, 0);
      chk("scoreboard drained", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
